debounce_sync: RTL and testbench

- Multi-channel input conditioner that sits directly upstream of the team's 4-bit `flop` register and drives its `d` bus.
- Takes raw asynchronous inputs (switches, buttons, external strobes), synchronises each bit through two flops, and debounces it with a per-channel stability counter.
- Presents a clean registered level per channel plus one-cycle rise/fall pulses for edge-triggered consumers.

---
 rtl/debounce_sync.sv | 80 ++++++++
 tb/tb_debounce_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// Multi-channel input conditioner: two-flop synchroniser followed by a per-channel
// stability counter, producing a clean level plus one-cycle rise/fall pulses.
module debounce_sync #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned     CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;
  logic [CW-1:0]    r_cnt [WIDTH];

  logic [WIDTH-1:0] w_dout_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;
  logic [CW-1:0]    w_cnt_nxt [WIDTH];

  // Per-channel stability filter: counter restarts whenever s2 agrees with dout.
  always_comb begin
    w_dout_nxt = r_dout;
    w_rise_nxt = '0;
    w_fall_nxt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_nxt[i] = '0;
      if (r_s2[i] != r_dout[i]) begin
        if (r_cnt[i] == CNT_MAX) begin
          w_dout_nxt[i] = r_s2[i];
          w_rise_nxt[i] = r_s2[i];
          w_fall_nxt[i] = ~r_s2[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_dout    <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1      <= din;
      r_s2      <= r_s1;
      r_dout    <= w_dout_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_changed <= |(w_rise_nxt | w_fall_nxt);
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign dout    = r_dout;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;

endmodule

// File: tb/tb_debounce_sync.sv
// Scoreboard bench for debounce_sync: default instance plus a STABLE_CYCLES=1 instance.
module tb_debounce_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic [3:0] dout, rise, fall;
  logic       changed;

  logic       reset1;
  logic [3:0] din1;
  logic [3:0] dout1, rise1, fall1;
  logic       changed1;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {dout, rise, fall, changed}, which instance, and a tag per cycle.
  logic [12:0] q_exp [$];
  bit          q_sel [$];
  string       q_tag [$];

  always #5 clk = ~clk;

  debounce_sync #(.WIDTH(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .din(din),
    .dout(dout), .rise(rise), .fall(fall), .changed(changed)
  );

  debounce_sync #(.WIDTH(4), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset1), .din(din1),
    .dout(dout1), .rise(rise1), .fall(fall1), .changed(changed1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input string tag, input bit sel, input int n,
                      input logic [3:0] d, input logic [3:0] r, input logic [3:0] f);
    for (int k = 0; k < n; k++) begin
      q_exp.push_back({d, r, f, |(r | f)});
      q_sel.push_back(sel);
      q_tag.push_back(tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle per queued expectation and compare against the selected instance.
  task automatic run(input int n);
    logic [12:0] e;
    logic [12:0] got;
    bit          s;
    string       t;
    for (int k = 0; k < n; k++) begin
      tick();
      if (q_exp.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: scoreboard empty at %0t", $time);
      end else begin
        e = q_exp.pop_front();
        s = q_sel.pop_front();
        t = q_tag.pop_front();
        got = s ? {dout1, rise1, fall1, changed1} : {dout, rise, fall, changed};
        check_eq(t, 32'(got), 32'(e));
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    reset1 = 1'b1;
    din    = 4'b0000;
    din1   = 4'b0000;
    din    = 4'b1111;
    din1   = 4'b1111;
    tick();

    // Reset state with inputs high: everything cleared, no pulses.
    push("rst0", 1'b0, 1, 4'b0000, 4'b0000, 4'b0000);
    run(1);
    push("rst1", 1'b1, 1, 4'b0000, 4'b0000, 4'b0000);
    run(1);
    din    = 4'b0000;
    din1   = 4'b0000;
    tick();
    tick();
    reset  = 1'b0;
    reset1 = 1'b0;

    // Idle low input: outputs stay quiet.
    push("idle", 1'b0, 20, 4'b0000, 4'b0000, 4'b0000);
    run(20);

    // Single-channel rise on the 6th edge.
    din = 4'b0001;
    push("rise_wait", 1'b0, 5, 4'b0000, 4'b0000, 4'b0000);
    push("rise_edge", 1'b0, 1, 4'b0001, 4'b0001, 4'b0000);
    push("rise_hold", 1'b0, 3, 4'b0001, 4'b0000, 4'b0000);
    run(9);

    // Two-cycle low glitch is rejected.
    din = 4'b0000;
    push("glitch_lo", 1'b0, 2, 4'b0001, 4'b0000, 4'b0000);
    run(2);
    din = 4'b0001;
    push("glitch_rej", 1'b0, 6, 4'b0001, 4'b0000, 4'b0000);
    run(6);
    check_eq("glitch_cnt", 32'(dut.r_cnt[0]), 32'd0);

    // Simultaneous rises and a fall in one cycle.
    din = 4'b1010;
    push("multi_wait", 1'b0, 5, 4'b0001, 4'b0000, 4'b0000);
    push("multi_edge", 1'b0, 1, 4'b1010, 4'b1010, 4'b0001);
    push("multi_hold", 1'b0, 3, 4'b1010, 4'b0000, 4'b0000);
    run(9);

    din = 4'b0000;
    push("fall_wait", 1'b0, 5, 4'b1010, 4'b0000, 4'b0000);
    push("fall_edge", 1'b0, 1, 4'b0000, 4'b0000, 4'b1010);
    push("fall_hold", 1'b0, 3, 4'b0000, 4'b0000, 4'b0000);
    run(9);

    // Reset mid-count on channel 3, then normal rise after release.
    din = 4'b1000;
    push("mid_count", 1'b0, 3, 4'b0000, 4'b0000, 4'b0000);
    run(3);
    reset = 1'b1;
    push("mid_rst", 1'b0, 1, 4'b0000, 4'b0000, 4'b0000);
    run(1);
    check_eq("mid_rst_cnt", 32'(dut.r_cnt[3]), 32'd0);
    reset = 1'b0;
    push("post_wait", 1'b0, 5, 4'b0000, 4'b0000, 4'b0000);
    push("post_edge", 1'b0, 1, 4'b1000, 4'b1000, 4'b0000);
    push("post_hold", 1'b0, 2, 4'b1000, 4'b0000, 4'b0000);
    run(8);

    // STABLE_CYCLES=1: synchroniser latency only, output on the 3rd edge.
    din1 = 4'b1100;
    push("s1_wait", 1'b1, 2, 4'b0000, 4'b0000, 4'b0000);
    push("s1_edge", 1'b1, 1, 4'b1100, 4'b1100, 4'b0000);
    push("s1_hold", 1'b1, 2, 4'b1100, 4'b0000, 4'b0000);
    run(5);

    din1 = 4'b0100;
    push("s1f_wait", 1'b1, 2, 4'b1100, 4'b0000, 4'b0000);
    push("s1f_edge", 1'b1, 1, 4'b0100, 4'b0000, 4'b1000);
    push("s1f_hold", 1'b1, 2, 4'b0100, 4'b0000, 4'b0000);
    run(5);

    if (q_exp.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_leftover: %0d entries unchecked", q_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
